// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg
// Brief    : EX/MEM pipeline register with multiply/divide stall control.
// Revision : 1.0
// ============================================================================
module ex_mem_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_md,
    input  logic            ex_branch,
    input  logic [4:0]      ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic            ex_memwrite,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_is_zero,
    input  logic            alu_ready,
    input  logic            mem_stall,
    output logic            stall_ex,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [XLEN-1:0] mem_br_target,
    output logic [4:0]      mem_rd,
    output logic            mem_regwrite,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            mem_br_taken,
    output logic            md_busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_HELD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_orphan;
    logic [XLEN-1:0]   r_held;
    logic              w_accept;
    logic              w_md_wait;

    // A ready pulse while orphan is set belongs to the redundant restart.
    assign w_accept  = ex_valid & ex_md & alu_ready & ~r_orphan;
    assign w_md_wait = ex_valid & ex_md & (r_state != MD_HELD) & ~w_accept;
    assign stall_ex  = mem_stall | w_md_wait;
    assign md_busy   = (r_state != RUN) | r_orphan;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_md_wait) w_state_nxt = MD_BUSY;
            MD_BUSY: if (w_accept)  w_state_nxt = mem_stall ? MD_HELD : RUN;
            MD_HELD: if (!mem_stall) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_orphan       <= 1'b0;
            r_held         <= '0;
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_br_target  <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_br_taken   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == MD_BUSY && w_accept && mem_stall)
                r_held <= alu_result;

            if (r_state == MD_HELD && !mem_stall)
                r_orphan <= 1'b1;
            else if (alu_ready)
                r_orphan <= 1'b0;

            if (!mem_stall) begin
                mem_rd         <= ex_rd;
                mem_regwrite   <= ex_regwrite;
                mem_memread    <= ex_memread;
                mem_memwrite   <= ex_memwrite;
                mem_store_data <= ex_store_data;
                mem_br_target  <= ex_br_target;
                if (r_state == MD_HELD) begin
                    mem_alu_result <= r_held;
                    mem_valid      <= 1'b1;
                    mem_br_taken   <= 1'b0;
                end else if (w_md_wait) begin
                    mem_alu_result <= alu_result;
                    mem_valid      <= 1'b0;
                    mem_br_taken   <= 1'b0;
                end else begin
                    mem_alu_result <= alu_result;
                    mem_valid      <= ex_valid;
                    mem_br_taken   <= ex_valid & ex_branch & alu_is_zero;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_reg
// Brief    : Scoreboard bench for the EX/MEM register and md stall control.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_md, ex_branch;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite;
    logic [31:0] ex_store_data, ex_br_target, alu_result;
    logic        alu_is_zero, alu_ready, mem_stall;
    logic        stall_ex, mem_valid;
    logic [31:0] mem_alu_result, mem_store_data, mem_br_target;
    logic [4:0]  mem_rd;
    logic        mem_regwrite, mem_memread, mem_memwrite, mem_br_taken, md_busy;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    ex_mem_reg #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_md(ex_md), .ex_branch(ex_branch), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_store_data(ex_store_data), .ex_br_target(ex_br_target),
        .alu_result(alu_result), .alu_is_zero(alu_is_zero), .alu_ready(alu_ready),
        .mem_stall(mem_stall), .stall_ex(stall_ex), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_br_target(mem_br_target), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_br_taken(mem_br_taken), .md_busy(md_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_md = 0; ex_branch = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0;
        ex_store_data = 0; ex_br_target = 0; alu_result = 0;
        alu_is_zero = 0; alu_ready = 0;
    endtask

    // Expected MEM contents built from the driven EX fields plus a hand value.
    task automatic push(input logic [31:0] res, input logic bt, input int c);
        exp_t e;
        e.res = res; e.sd = ex_store_data; e.tgt = ex_br_target; e.rd = ex_rd;
        e.ctl = {ex_regwrite, ex_memread, ex_memwrite, bt};
        e.cyc = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (mem_valid && !mem_stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result 0x%08h expected no output", mem_alu_result);
            end else begin
                e = sb.pop_front();
                chk("sb_result", mem_alu_result, e.res);
                chk("sb_rd", {27'd0, mem_rd}, {27'd0, e.rd});
                chk("sb_ctl", {28'd0, mem_regwrite, mem_memread, mem_memwrite, mem_br_taken},
                    {28'd0, e.ctl});
                chk("sb_store", mem_store_data, e.sd);
                chk("sb_target", mem_br_target, e.tgt);
                chk("sb_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c0, bad, vbad;
        rst_n = 0; mem_stall = 0; idle();
        repeat (2) nxt();
        @(negedge clk);
        chk("rst_valid", {31'd0, mem_valid}, 0);
        chk("rst_result", mem_alu_result, 0);
        chk("rst_ctl", {23'd0, mem_rd, mem_regwrite, mem_memread, mem_memwrite, mem_br_taken}, 0);
        chk("rst_stall", {31'd0, stall_ex}, 0);
        chk("rst_busy", {31'd0, md_busy}, 0);
        nxt();
        rst_n = 1;

        // ADD
        ex_valid = 1; alu_result = 32'h7; ex_rd = 5; ex_regwrite = 1;
        push(32'h7, 0, cyc + 1);
        @(negedge clk); chk("add_stall", {31'd0, stall_ex}, 0);
        nxt(); idle();

        // MUL, full 33-cycle latency
        c0 = cyc; bad = 0; vbad = 0;
        ex_valid = 1; ex_md = 1; ex_rd = 7; ex_regwrite = 1; alu_result = 32'hDEAD0000;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (stall_ex !== 1'b1) bad++;
            if (i > 0 && mem_valid !== 1'b0) vbad++;
            nxt();
        end
        alu_ready = 1; alu_result = 32'hC;
        push(32'hC, 0, c0 + 34);
        @(negedge clk); chk("mul_ready_stall", {31'd0, stall_ex}, 0);
        nxt(); idle();
        chk("mul_stall_cycles", bad, 0);
        chk("mul_bubble", vbad, 0);

        // BEQ taken, BNE not taken, store pass-through
        ex_valid = 1; ex_branch = 1; alu_is_zero = 1; ex_br_target = 32'h100; alu_result = 32'h104;
        push(32'h104, 1, cyc + 1);
        nxt();
        alu_is_zero = 0; ex_br_target = 32'h200; alu_result = 32'h0;
        push(32'h0, 0, cyc + 1);
        nxt();
        ex_branch = 0; ex_memwrite = 1; ex_store_data = 32'hCAFEF00D; alu_result = 32'h40;
        push(32'h40, 0, cyc + 1);
        nxt(); idle();

        // DIV finishing while MEM is stalled
        ex_valid = 1; ex_md = 1; ex_rd = 9; ex_regwrite = 1; alu_result = 32'h1111;
        repeat (4) nxt();
        mem_stall = 1; alu_ready = 1; alu_result = 32'h3;
        @(negedge clk); chk("div_ready_stall", {31'd0, stall_ex}, 1);
        nxt();
        alu_ready = 0; alu_result = 32'h5555; bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (stall_ex !== 1'b1 || md_busy !== 1'b1) bad++;
            nxt();
        end
        chk("div_held_stall", bad, 0);
        mem_stall = 0;
        push(32'h3, 0, cyc + 1);
        @(negedge clk); chk("div_release_stall", {31'd0, stall_ex}, 0);
        nxt();

        // ADD behind the held DIV, orphan pending
        ex_md = 0; ex_rd = 3; alu_result = 32'h11;
        push(32'h11, 0, cyc + 1);
        @(negedge clk);
        chk("orphan_busy", {31'd0, md_busy}, 1);
        chk("add2_stall", {31'd0, stall_ex}, 0);
        nxt();

        // MUL must skip the orphan ready pulse
        ex_md = 1; ex_rd = 4; alu_result = 32'h9999;
        @(negedge clk); chk("orph_mul_stall", {31'd0, stall_ex}, 1);
        nxt(); nxt();
        alu_ready = 1; alu_result = 32'hBAD;
        @(negedge clk); chk("orph_pulse_stall", {31'd0, stall_ex}, 1);
        nxt();
        alu_ready = 0; alu_result = 32'h9999;
        repeat (3) nxt();
        alu_ready = 1; alu_result = 32'h2A;
        push(32'h2A, 0, cyc + 1);
        @(negedge clk); chk("mul2_stall", {31'd0, stall_ex}, 0);
        nxt(); idle();
        @(negedge clk); chk("idle_busy", {31'd0, md_busy}, 0);
        nxt();

        // Reset in the middle of MD_BUSY
        ex_valid = 1; ex_md = 1; ex_rd = 12; ex_regwrite = 1; ex_memread = 1;
        ex_store_data = 32'h1234; ex_br_target = 32'h88; alu_result = 32'h777;
        repeat (10) nxt();
        @(negedge clk); chk("pre_rst_busy", {31'd0, md_busy}, 1);
        rst_n = 0;
        nxt();
        rst_n = 1; idle();
        @(negedge clk);
        chk("mrst_busy", {31'd0, md_busy}, 0);
        chk("mrst_valid", {31'd0, mem_valid}, 0);
        chk("mrst_result", mem_alu_result, 0);
        chk("mrst_data", mem_store_data | mem_br_target, 0);
        chk("mrst_ctl", {23'd0, mem_rd, mem_regwrite, mem_memread, mem_memwrite, mem_br_taken}, 0);
        chk("mrst_stall", {31'd0, stall_ex}, 0);
        repeat (2) nxt();
        chk("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
